// File: rtl/video_retimer.sv
// rtl/video_retimer.sv - retimes a bursty pixel stream onto a free-running display raster
// A FIFO holds input pixels; each frame locks to the raster origin once PREFILL pixels are buffered.
module video_retimer #(
  parameter int H_SYNC     = 44,
  parameter int H_BACK     = 148,
  parameter int H_DISP     = 1920,
  parameter int H_FRONT    = 88,
  parameter int V_SYNC     = 5,
  parameter int V_BACK     = 36,
  parameter int V_DISP     = 1080,
  parameter int V_FRONT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int FIFO_AW    = 12,
  parameter int PREFILL    = 1920,
  parameter logic [DATA_WIDTH*CHANNELS-1:0] FILL_COLOR = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_start_i,
  input  logic [DATA_WIDTH*CHANNELS-1:0] data_i,
  input  logic                           data_valid_i,
  output logic                           hs_o,
  output logic                           vs_o,
  output logic                           de_o,
  output logic [DATA_WIDTH*CHANNELS-1:0] rgb_o,
  output logic                           underflow_o,
  output logic                           overflow_o,
  output logic [FIFO_AW:0]               fifo_level_o
);
  localparam int PW      = DATA_WIDTH * CHANNELS;
  localparam int LW      = FIFO_AW + 1;
  localparam int DEPTH   = 2 ** FIFO_AW;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_C = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_F  = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_L  = HW'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_C = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_F  = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_SYNC + V_BACK + V_DISP - 1);
  localparam logic [LW-1:0] FULL_LVL    = LW'(DEPTH);
  localparam logic [LW-1:0] PREFILL_LVL = LW'(PREFILL);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

  state_t             r_state;
  logic [HW-1:0]      r_h_cnt;
  logic [VW-1:0]      r_v_cnt;
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [LW-1:0]      r_level;
  logic [PW-1:0]      r_mem [DEPTH];

  logic w_h_wrap, w_origin, w_act, w_last_act, w_empty, w_full, w_pop, w_wr;

  assign w_h_wrap   = (r_h_cnt == H_LAST);
  assign w_origin   = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_act      = (r_h_cnt >= H_ACT_F) && (r_h_cnt <= H_ACT_L) &&
                      (r_v_cnt >= V_ACT_F) && (r_v_cnt <= V_ACT_L);
  assign w_last_act = (r_h_cnt == H_ACT_L) && (r_v_cnt == V_ACT_L);
  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == FULL_LVL);
  assign w_pop      = (r_state == S_RUN) && w_act && !w_empty && !frame_start_i;
  // A flush frees the whole FIFO, so a pixel arriving with frame_start always lands.
  assign w_wr       = data_valid_i && (!w_full || w_pop || frame_start_i);

  assign fifo_level_o = r_level;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      hs_o        <= 1'b0;
      vs_o        <= 1'b0;
      de_o        <= 1'b0;
      rgb_o       <= '0;
      underflow_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + HW'(1);
      if (w_h_wrap) r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);

      hs_o  <= (r_h_cnt < H_SYNC_C);
      vs_o  <= (r_v_cnt < V_SYNC_C);
      de_o  <= w_act;
      rgb_o <= !w_act ? '0 : (w_pop ? r_mem[r_rd_ptr] : FILL_COLOR);

      if (frame_start_i) begin
        underflow_o <= 1'b0;
        overflow_o  <= 1'b0;
      end else begin
        if ((r_state == S_RUN) && w_act && w_empty) underflow_o <= 1'b1;
        if (data_valid_i && !w_wr) overflow_o <= 1'b1;
      end

      if (frame_start_i) begin
        r_rd_ptr <= r_wr_ptr;
        r_wr_ptr <= w_wr ? r_wr_ptr + FIFO_AW'(1) : r_wr_ptr;
        r_level  <= w_wr ? LW'(1) : '0;
      end else begin
        if (w_wr)  r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
        if (w_wr && !w_pop)      r_level <= r_level + LW'(1);
        else if (!w_wr && w_pop) r_level <= r_level - LW'(1);
      end

      if (frame_start_i) begin
        r_state <= S_ARM;
      end else begin
        case (r_state)
          S_ARM:   if (w_origin && (r_level >= PREFILL_LVL)) r_state <= S_RUN;
          S_RUN:   if (w_last_act) r_state <= S_IDLE;
          default: r_state <= r_state;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_video_retimer.sv
// tb/tb_video_retimer.sv - directed checks of raster timing, FIFO fill/drain and fault flags
module tb_video_retimer;
  localparam logic [23:0] FILL = 24'h123456;
  localparam int NEVER = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fs = 1'b0;
  logic        dv = 1'b0;
  logic [23:0] din = '0;
  logic        hs, vs, de, uf, ov;
  logic [23:0] rgb;
  logic [5:0]  lvl;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = -1;

  logic [23:0] exp_pix [32];

  typedef struct {
    int          cyc;
    logic        fs;
    logic        dv;
    logic [23:0] d;
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic [5:0]  lvl;
  } vec_t;
  vec_t tbl [14];

  always #5 clk = ~clk;

  video_retimer #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .DATA_WIDTH(8), .CHANNELS(3), .FIFO_AW(5), .PREFILL(8),
    .FILL_COLOR(24'h123456)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start_i(fs), .data_i(din), .data_valid_i(dv),
    .hs_o(hs), .vs_o(vs), .de_o(de), .rgb_o(rgb),
    .underflow_o(uf), .overflow_o(ov), .fifo_level_o(lvl)
  );

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic goto(input int t);
    while (k < t) step();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  function automatic logic e_hs(input int t);
    return (t % 14) < 2;
  endfunction

  function automatic logic e_vs(input int t);
    return ((t / 14) % 7) < 1;
  endfunction

  function automatic logic e_de(input int t);
    int h;
    int v;
    h = t % 14;
    v = (t / 14) % 7;
    return (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
  endfunction

  function automatic int pix_idx(input int t);
    return (((t / 14) % 7) - 2) * 8 + ((t % 14) - 4);
  endfunction

  // Walks one full frame from origin o, comparing raster, pixel and underflow per cycle.
  task automatic check_frame(input string name, input int o, input int uf_at);
    for (int t = o; t < o + 98; t++) begin
      logic        ed;
      logic [23:0] er;
      goto(t);
      ed = e_de(t);
      er = ed ? exp_pix[pix_idx(t)] : 24'h0;
      chk(name, {hs, vs, de, rgb, uf}, {e_hs(t), e_vs(t), ed, er, (t >= uf_at)});
    end
  endtask

  task automatic send(input int a, input logic [23:0] base, input int n);
    goto(a - 1);
    fs = 1'b1;
    step();
    fs = 1'b0;
    for (int i = 0; i < n; i++) begin
      dv  = 1'b1;
      din = base + 24'(i);
      step();
    end
    dv = 1'b0;
  endtask

  task automatic fill_exp(input logic [23:0] base, input int n);
    for (int i = 0; i < 32; i++) exp_pix[i] = (i < n) ? base + 24'(i) : FILL;
  endtask

  initial begin
    tbl[0]  = '{0,   0, 0, 24'h0,  1, 1, 0, 24'h0, 6'd0};
    tbl[1]  = '{1,   0, 1, 24'h11, 1, 1, 0, 24'h0, 6'd1};
    tbl[2]  = '{2,   0, 0, 24'h0,  0, 1, 0, 24'h0, 6'd1};
    tbl[3]  = '{14,  0, 1, 24'h22, 1, 0, 0, 24'h0, 6'd2};
    tbl[4]  = '{32,  0, 0, 24'h0,  0, 0, 1, FILL,  6'd2};
    tbl[5]  = '{33,  0, 1, 24'h33, 0, 0, 1, FILL,  6'd3};
    tbl[6]  = '{39,  0, 0, 24'h0,  0, 0, 1, FILL,  6'd3};
    tbl[7]  = '{40,  0, 0, 24'h0,  0, 0, 0, 24'h0, 6'd3};
    tbl[8]  = '{74,  0, 0, 24'h0,  0, 0, 1, FILL,  6'd3};
    tbl[9]  = '{83,  0, 0, 24'h0,  0, 0, 0, 24'h0, 6'd3};
    tbl[10] = '{84,  0, 0, 24'h0,  1, 0, 0, 24'h0, 6'd3};
    tbl[11] = '{98,  0, 0, 24'h0,  1, 1, 0, 24'h0, 6'd3};
    tbl[12] = '{101, 0, 0, 24'h0,  0, 1, 0, 24'h0, 6'd3};
    tbl[13] = '{102, 0, 0, 24'h0,  0, 1, 0, 24'h0, 6'd3};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {hs, vs, de, rgb, uf, ov, lvl}, 64'h0);
    rst_n = 1'b1;
    k = -1;
    chk("pre_origin_hs", hs, 1'b0);

    // Idle raster with a few writes landing while no frame is armed
    for (int i = 0; i < 14; i++) begin
      goto(tbl[i].cyc - 1);
      fs  = tbl[i].fs;
      dv  = tbl[i].dv;
      din = tbl[i].d;
      step();
      fs = 1'b0;
      dv = 1'b0;
      chk("idle_vec", {hs, vs, de, rgb, lvl},
          {tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].rgb, tbl[i].lvl});
    end
    fill_exp(24'h0, 0);
    check_frame("idle_frame", 196, NEVER);

    // Full 32-pixel frame
    send(304, 24'h0, 32);
    chk("full_level", {lvl, ov}, {6'd32, 1'b0});
    fill_exp(24'h0, 32);
    check_frame("full_frame", 392, NEVER);
    chk("full_drained", {lvl, uf}, {6'd0, 1'b0});
    fill_exp(24'h0, 0);
    check_frame("back_to_idle", 490, NEVER);

    // Only 8 pixels: underflow from line 1 onwards
    send(598, 24'h0, 8);
    fill_exp(24'h0, 8);
    check_frame("short_frame", 686, 732);

    // 40 pixels into a 32-deep FIFO with nothing draining
    goto(793);
    fs = 1'b1;
    step();
    fs = 1'b0;
    for (int i = 0; i < 40; i++) begin
      dv  = 1'b1;
      din = 24'h40 + 24'(i);
      step();
      if (i == 31) chk("ovf_at_full", {lvl, ov}, {6'd32, 1'b0});
      if (i == 32) chk("ovf_first_drop", {lvl, ov}, {6'd32, 1'b1});
    end
    dv = 1'b0;
    fill_exp(24'h40, 32);
    check_frame("ovf_frame", 882, NEVER);
    chk("ovf_sticky", {lvl, ov}, {6'd0, 1'b1});

    // frame_start mid-RUN with a coincident pixel
    send(990, 24'hC0, 40);
    goto(1117);
    chk("mid_run_pre", {lvl, ov}, {6'd24, 1'b1});
    fs  = 1'b1;
    dv  = 1'b1;
    din = 24'hAA;
    step();
    fs = 1'b0;
    chk("mid_run_flush", {lvl, ov, uf, de}, {6'd1, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 7; i++) begin
      din = 24'hAB + 24'(i);
      step();
    end
    dv = 1'b0;
    goto(1138);
    chk("armed_fill", {de, rgb, lvl, uf}, {1'b1, FILL, 6'd8, 1'b0});
    fill_exp(24'hAA, 8);
    check_frame("restart_frame", 1176, 1222);

    // Asynchronous reset mid-line
    send(1284, 24'h50, 5);
    goto(1306);
    chk("pre_reset", {de, rgb, lvl}, {1'b1, FILL, 6'd5});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {hs, vs, de, rgb, uf, ov, lvl}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = -1;
    chk("post_reset_wait", {hs, vs, lvl}, 64'h0);
    step();
    chk("post_reset_origin", {hs, vs, de, lvl}, {1'b1, 1'b1, 1'b0, 6'd0});
    step();
    step();
    chk("post_reset_h2", {hs, vs}, {1'b0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
